// File: rtl/pipe_skid_reg.sv
// Generic pipeline-stage register with a valid/ready handshake, global enable and flush.
// With SKID=1 a second entry absorbs one beat, so up_ready comes from state only.
// With SKID=0 a single register is used and up_ready passes dn_ready through.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       SKID       = 1,
  parameter logic [DATA_W-1:0] RESET_VAL  = {DATA_W{1'b0}},
  parameter logic [DATA_W-1:0] FLUSH_MASK = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_en,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy
);

  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              active;
  logic              up_xfer;
  logic              dn_xfer;

  // Masked bits return to their reset value on flush; unmasked bits keep their contents.
  function automatic logic [DATA_W-1:0] flushed(input logic [DATA_W-1:0] v);
    return (v & ~FLUSH_MASK) | (RESET_VAL & FLUSH_MASK);
  endfunction

  assign active    = cpu_en & ~flush;
  assign dn_valid  = active & (occ_q != 2'd0);
  assign dn_xfer   = dn_valid & dn_ready;
  assign up_xfer   = active & up_valid & up_ready;
  assign dn_data   = main_q;
  assign occupancy = occ_q;

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] skid_q, skid_d;

    // Registered ready: depends only on the occupancy flops.
    assign up_ready = cpu_en & (occ_q != 2'd2);

    // Next-state for the two-entry buffer; main always holds the oldest entry.
    always_comb begin
      occ_d  = occ_q;
      main_d = main_q;
      skid_d = skid_q;
      if (cpu_en) begin
        if (flush) begin
          occ_d  = 2'd0;
          main_d = flushed(main_q);
          skid_d = flushed(skid_q);
        end else begin
          case (occ_q)
            2'd0: begin
              if (up_xfer) begin
                occ_d  = 2'd1;
                main_d = up_data;
              end
            end
            2'd1: begin
              if (up_xfer && dn_xfer) begin
                main_d = up_data;
              end else if (up_xfer) begin
                occ_d  = 2'd2;
                skid_d = up_data;
              end else if (dn_xfer) begin
                occ_d  = 2'd0;
              end
            end
            2'd2: begin
              if (dn_xfer) begin
                occ_d  = 2'd1;
                main_d = skid_q;
              end
            end
            default: ;
          endcase
        end
      end
    end

    // Skid payload register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_q <= RESET_VAL;
      end else begin
        skid_q <= skid_d;
      end
    end
  end else begin : g_noskid
    // Accept when empty or when the held beat leaves this same cycle.
    assign up_ready = active & ((occ_q == 2'd0) | dn_ready);

    // Next-state for the single-entry register.
    always_comb begin
      occ_d  = occ_q;
      main_d = main_q;
      if (cpu_en && flush) begin
        occ_d  = 2'd0;
        main_d = flushed(main_q);
      end else if (up_xfer) begin
        occ_d  = 2'd1;
        main_d = up_data;
      end else if (dn_xfer) begin
        occ_d  = 2'd0;
      end
    end
  end

  // Occupancy and main payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      main_q <= RESET_VAL;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: one SKID=0 and one SKID=1 instance share the same stimulus.
// Each lane has a FIFO reference model; the negedge monitor checks all outputs against it.
module tb_pipe_skid_reg;

  localparam logic [7:0] Mask = 8'h0F;
  localparam logic [7:0] Rv   = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_en = 1'b0;
  logic       flush = 1'b0;
  logic       up_valid = 1'b0;
  logic       dn_ready = 1'b0;
  logic [7:0] up_data = 8'h00;

  logic [1:0] ur;
  logic [1:0] dv;
  logic [7:0] dd [2];
  logic [1:0] oc [2];

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(8), .SKID(0), .RESET_VAL(Rv), .FLUSH_MASK(Mask)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_en   (cpu_en),
    .flush    (flush),
    .up_valid (up_valid),
    .up_ready (ur[0]),
    .up_data  (up_data),
    .dn_valid (dv[0]),
    .dn_ready (dn_ready),
    .dn_data  (dd[0]),
    .occupancy(oc[0])
  );

  pipe_skid_reg #(.DATA_W(8), .SKID(1), .RESET_VAL(Rv), .FLUSH_MASK(Mask)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_en   (cpu_en),
    .flush    (flush),
    .up_valid (up_valid),
    .up_ready (ur[1]),
    .up_data  (up_data),
    .dn_valid (dv[1]),
    .dn_ready (dn_ready),
    .dn_data  (dd[1]),
    .occupancy(oc[1])
  );

  // Reference model: a FIFO of accepted payloads per lane, plus the last value seen at the head.
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] main_m [2];
  int         vectors = 0;
  int         miscompares = 0;

  function automatic int qsize(input int l);
    return (l == 1) ? q1.size() : q0.size();
  endfunction

  function automatic logic [7:0] qfront(input int l);
    return (l == 1) ? q1[0] : q0[0];
  endfunction

  function automatic void qpush(input int l, input logic [7:0] v);
    if (l == 1) q1.push_back(v);
    else q0.push_back(v);
  endfunction

  function automatic void qpop(input int l);
    if (l == 1) void'(q1.pop_front());
    else void'(q0.pop_front());
  endfunction

  function automatic void qclear(input int l);
    if (l == 1) q1.delete();
    else q0.delete();
  endfunction

  function automatic void chk(input string nm, input int l, input logic [7:0] act,
                              input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lane%0d (skid=%0d) t=%0t: got %h, want %h", nm, l, l, $time, act, exp);
    end
  endfunction

  // Monitor: compare outputs mid-cycle, then advance the model to the next clock edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      qclear(0);
      qclear(1);
      main_m[0] = Rv;
      main_m[1] = Rv;
    end else begin
      for (int l = 0; l < 2; l++) begin
        int         sz;
        logic       e_ur;
        logic       e_dv;
        logic [7:0] cur;
        sz   = qsize(l);
        cur  = (sz != 0) ? qfront(l) : main_m[l];
        e_dv = cpu_en & ~flush & (sz != 0);
        if (l == 1) e_ur = cpu_en & (sz < 2);
        else e_ur = cpu_en & ~flush & ((sz == 0) | dn_ready);
        chk("occupancy", l, {6'd0, oc[l]}, sz[7:0]);
        chk("dn_valid", l, {7'd0, dv[l]}, {7'd0, e_dv});
        chk("up_ready", l, {7'd0, ur[l]}, {7'd0, e_ur});
        chk("dn_data", l, dd[l], cur);
        if (cpu_en && flush) begin
          main_m[l] = (cur & ~Mask) | (Rv & Mask);
          qclear(l);
        end else if (cpu_en) begin
          main_m[l] = cur;
          if (e_dv && dn_ready) qpop(l);
          if (up_valid && e_ur) qpush(l, up_data);
          if (qsize(l) != 0) main_m[l] = qfront(l);
        end
      end
    end
  end

  // Drive one cycle of inputs, then move to just after the next rising edge.
  task automatic cyc(input logic uv, input logic [7:0] d, input logic dr, input logic ce,
                     input logic fl);
    up_valid = uv;
    up_data  = d;
    dn_ready = dr;
    cpu_en   = ce;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cpu_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming at full rate.
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Backpressure fills the skid entry, then drains in order.
    cyc(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Flush with a competing upstream beat; low nibble clears, high nibble holds.
    cyc(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Global enable low freezes everything, then resumes.
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 8'h88, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h88, 1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Flush is ignored while disabled.
    cyc(1'b1, 8'hD1, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 8'hD2, 1'b1, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of traffic.
    cyc(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) cyc(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'hC4, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 9, $urandom_range(0, 19) == 0);
    end
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Generic parametrised pipeline-stage register that replaces hand-written per-stage registers such as the ex→mem register.
- Carries a DATA_W-bit bundle between stages with a valid/ready handshake, global cpu_en gating and synchronous flush.
- Adds an optional 2-entry skid buffer so the ready path can be fully registered.
- FLUSH_MASK selects which bits are cleared on flush; unmasked bits hold on flush, e.g. ebreak/ecall flags.

Parameters:
- DATA_W, 64: width of the payload bundle.
- SKID, 1: 1 = 2-entry skid buffer with registered up_ready; 0 = single register with combinational up_ready.
- RESET_VAL, {DATA_W{1'b0}}: value loaded into payload registers on reset, and on flush for masked bits.
- FLUSH_MASK, {DATA_W{1'b1}}: bit i = 1 means payload bit i is reloaded with RESET_VAL[i] on flush; 0 means it holds.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cpu_en  in  1  global enable; 0 freezes all state
- flush  in  1  synchronous flush, valid only when cpu_en=1
- up_valid  in  1  upstream payload valid
- up_ready  out  1  stage can accept
- up_data  in  DATA_W  upstream payload
- dn_valid  out  1  payload available downstream
- dn_ready  in  1  downstream accepts
- dn_data  out  DATA_W  payload to downstream (registered)
- occupancy  out  2  entries held: 0, 1 or 2 (2 only when SKID=1)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: occupancy=0, main and skid payload registers = RESET_VAL, dn_valid=0, dn_data=RESET_VAL. With SKID=1, up_ready=1 after reset.
- Transfers:
  - up_xfer = up_valid & up_ready.
  - dn_xfer = dn_valid & dn_ready.
  - Both are evaluated only when cpu_en=1 and flush=0.
- cpu_en=0:
  - up_ready=0 and dn_valid=0, forced combinationally.
  - All registers hold; no transfer occurs.
- dn_valid = cpu_en & ~flush & (occupancy!=0). dn_data is always the main register, including when dn_valid=0.
- SKID=1 state machine on occupancy:
  - EMPTY(0): up_xfer → ONE; main <= up_data.
  - ONE(1):
    - up_xfer & dn_xfer → ONE; main <= up_data.
    - up_xfer & ~dn_xfer → TWO; skid <= up_data.
    - ~up_xfer & dn_xfer → EMPTY.
    - Otherwise hold.
  - TWO(2): up_ready=0. dn_xfer → ONE; main <= skid. Otherwise hold.
  - up_ready = cpu_en & (occupancy!=2). It is a function of registered state only; there is no combinational path from dn_ready.
- SKID=0:
  - Only EMPTY/ONE exist; the skid register is not instantiated.
  - up_ready = cpu_en & ~flush & (occupancy==0 | dn_ready).
  - up_xfer loads main. dn_xfer without up_xfer → EMPTY.
- Latency: 1 cycle from up_xfer to dn_valid when the stage is empty. Ordering is strictly FIFO; no payload is duplicated or dropped except by flush.
- Flush (cpu_en=1, flush=1):
  - occupancy <= 0.
  - In main and skid, bits with FLUSH_MASK=1 <= RESET_VAL; bits with FLUSH_MASK=0 hold.
  - Flush overrides any same-cycle up_valid: the incoming payload is dropped.
  - dn_valid is forced 0 in the flush cycle, so downstream never consumes flushed data.
  - SKID=1: up_ready is still driven from state, but the payload is discarded.
- flush while cpu_en=0: ignored, state holds.
- Reset mid-operation: immediate return to reset values. Any payload in flight is lost.
- Counter: occupancy never exceeds 2 (SKID=1) or 1 (SKID=0) and never underflows. up_xfer in TWO is impossible by construction.

Test Plan:
1. Reset, SKID=1, DATA_W=8: drive rst_n=0 mid-stream → occupancy=0, dn_valid=0, dn_data=RESET_VAL, up_ready=1 immediately after rst_n rises.
2. Streaming: dn_ready=1, push 0x11,0x22,0x33 on consecutive cycles → dn_data shows 0x11,0x22,0x33 one cycle later each, occupancy stays 1, up_ready stays 1.
3. Backpressure/skid: hold dn_ready=0, push 0xA1,0xA2 → occupancy=2, up_ready=0. Then release dn_ready → outputs 0xA1 then 0xA2, up_ready returns to 1 after the first dn_xfer.
4. Flush with FLUSH_MASK=8'h0F, RESET_VAL=0: stage holds 0xA5 (and skid holds 0x5A); assert flush together with up_valid and data 0xFF → occupancy=0, dn_valid=0 that cycle, main=0xA0, skid=0x50, 0xFF never appears downstream.
5. cpu_en=0 for 3 cycles with occupancy=1, data 0x77, up_valid=1, dn_ready=1 → up_ready=0, dn_valid=0, state unchanged. Re-enable → 0x77 delivered, then the new payload.
6. SKID=0: dn_ready=0 with the stage full → up_ready=0 the same cycle. With dn_ready=1 and up_valid=1 → simultaneous transfer, occupancy stays 1, throughput 1 per cycle.
